// File: rtl/mdu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mdu_pkg                                            |
// | Description : Shared op codes, FSM states and latency constant   |
// |               for the iterative multiply/divide unit.            |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package mdu_pkg;

  // Operation encoding on the op port
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  // Control FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Start-to-done latency in cycles: WIDTH iterations, one fix-up, one done
  function automatic int mdu_latency(input int width);
    return width + 2;
  endfunction

  localparam int MDU_WIDTH   = 32;
  localparam int MDU_LATENCY = mdu_latency(MDU_WIDTH);

endpackage
`default_nettype wire

// File: rtl/mdu_sign_fix.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mdu_sign_fix                                       |
// | Description : Combinational post-processing of the unsigned      |
// |               magnitude result: sign correction and the          |
// |               divide-by-zero substitution.                       |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]         op_i,
  input  logic [2*WIDTH-1:0] mag_i,     // product, or {remainder, quotient}
  input  logic               sign_a_i,
  input  logic               sign_b_i,
  input  logic               dz_i,
  input  logic [WIDTH-1:0]   a_raw_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               neg;

  // Apply operand signs to the magnitude result, or substitute the div-by-zero pattern
  always_comb begin
    neg  = sign_a_i ^ sign_b_i;
    prod = mag_i;
    quo  = mag_i[WIDTH-1:0];
    rem  = mag_i[2*WIDTH-1:WIDTH];
    hi_o = '0;
    lo_o = '0;
    case (op_i)
      OP_MULTU: begin
        hi_o = prod[2*WIDTH-1:WIDTH];
        lo_o = prod[WIDTH-1:0];
      end
      OP_MULT: begin
        if (neg) prod = -mag_i;
        hi_o = prod[2*WIDTH-1:WIDTH];
        lo_o = prod[WIDTH-1:0];
      end
      default: begin
        if (dz_i) begin
          hi_o = a_raw_i;
          lo_o = '1;
        end else begin
          // Unsigned divides carry zero signs, so this is a no-op for DIVU
          if (neg)      quo = -mag_i[WIDTH-1:0];
          if (sign_a_i) rem = -mag_i[2*WIDTH-1:WIDTH];
          hi_o = rem;
          lo_o = quo;
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : mdu_iter                                           |
// | Description : Fixed-latency iterative multiply/divide unit.      |
// |               Shift-add multiply and restoring divide on         |
// |               unsigned magnitudes, one bit per cycle, with a     |
// |               registered HI/LO result and a one-cycle done.      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic               load;

  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;      // {upper, lower} shared by mul and div
  logic [WIDTH-1:0]   opnd_q;            // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_raw_q;           // raw dividend for the div-by-zero result
  logic [1:0]         op_q;
  logic               sign_a_q, sign_b_q, dz_q;

  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shl;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a new op is accepted only from IDLE or DONE
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          load    = 1'b1;
        end
      end
      CALC: begin
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d = CALC;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes; -2^(WIDTH-1) maps to itself, which is exact as unsigned
  always_comb begin
    sign_a = op[0] & a[WIDTH-1];
    sign_b = op[0] & b[WIDTH-1];
    mag_a  = sign_a ? -a : a;
    mag_b  = sign_b ? -b : b;
  end

  // One multiply or divide step on the accumulator
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    shl   = {acc_q, 1'b0};
    trial = shl[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    acc_d = acc_q;
    if (!op_q[1]) begin
      // add into the upper half when the multiplier LSB is set, then shift right with carry
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      // trial subtraction fits: keep it, quotient bit 1
      acc_d = {trial[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
    end else begin
      // restore: keep the shifted remainder, quotient bit 0
      acc_d = {shl[2*WIDTH-1:1], 1'b0};
    end
  end

  mdu_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .op_i     (op_q),
    .mag_i    (acc_q),
    .sign_a_i (sign_a_q),
    .sign_b_i (sign_b_q),
    .dz_i     (dz_q),
    .a_raw_i  (a_raw_q),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  // Operand latch, iteration datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_raw_q  <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      if (load) begin
        op_q     <= op;
        sign_a_q <= sign_a;
        sign_b_q <= sign_b;
        dz_q     <= op[1] & (b == '0);
        a_raw_q  <= a;
        opnd_q   <= op[1] ? mag_b : mag_a;
        acc_q    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
        cnt_q    <= '0;
      end else if (state_q == CALC) begin
        acc_q <= acc_d;
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == FIX) begin
        hi_q  <= fix_hi;
        lo_q  <= fix_lo;
        dbz_q <= dz_q;
      end
    end
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
